// File: rtl/lnrv_exu_flush_sched.sv
// Registered flush scheduler: fixed-priority arbitration of EXU flush sources onto the IFU flush port,
// with a held request until IFU ack and a programmable refill gap afterwards.
module lnrv_exu_flush_sched #(
    parameter int unsigned FLUSH_GAP = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        brch_flush_req,
    input  logic [31:0] brch_flush_pc_op1,
    input  logic [31:0] brch_flush_pc_op2,
    input  logic        excp_flush_req,
    input  logic [31:0] excp_flush_pc_op1,
    input  logic [31:0] excp_flush_pc_op2,
    input  logic        irq_flush_req,
    input  logic [31:0] irq_flush_pc_op1,
    input  logic [31:0] irq_flush_pc_op2,
    input  logic        debug_flush_req,
    input  logic [31:0] debug_flush_pc_op1,
    input  logic [31:0] debug_flush_pc_op2,
    output logic        brch_flush_ack,
    output logic        excp_flush_ack,
    output logic        irq_flush_ack,
    output logic        debug_flush_ack,
    output logic        pipe_flush_req,
    input  logic        pipe_flush_ack,
    output logic [31:0] pipe_flush_pc,
    output logic [3:0]  pipe_flush_src,
    output logic        flush_busy,
    output logic [31:0] flush_cnt
);

    localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'(FLUSH_GAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [31:0]        pc_q, pc_d;
    logic [3:0]         src_q, src_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [31:0]        flush_cnt_q, flush_cnt_d;
    logic               busy_q, busy_d;

    logic [31:0]        sel_op1, sel_op2, sel_sum;
    logic [3:0]         sel_src;

    // Fixed priority: brch > excp > irq > debug
    always_comb begin
        sel_op1 = debug_flush_pc_op1;
        sel_op2 = debug_flush_pc_op2;
        sel_src = 4'b1000;
        if (brch_flush_req) begin
            sel_op1 = brch_flush_pc_op1;
            sel_op2 = brch_flush_pc_op2;
            sel_src = 4'b0001;
        end else if (excp_flush_req) begin
            sel_op1 = excp_flush_pc_op1;
            sel_op2 = excp_flush_pc_op2;
            sel_src = 4'b0010;
        end else if (irq_flush_req) begin
            sel_op1 = irq_flush_pc_op1;
            sel_op2 = irq_flush_pc_op2;
            sel_src = 4'b0100;
        end
        sel_sum = sel_op1 + sel_op2;
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        pc_d            = pc_q;
        src_d           = src_q;
        gap_d           = gap_q;
        flush_cnt_d     = flush_cnt_q;
        brch_flush_ack  = 1'b0;
        excp_flush_ack  = 1'b0;
        irq_flush_ack   = 1'b0;
        debug_flush_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (brch_flush_req || excp_flush_req || irq_flush_req || debug_flush_req) begin
                    pc_d    = {sel_sum[31:1], 1'b0};
                    src_d   = sel_src;
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (pipe_flush_ack) begin
                    brch_flush_ack  = src_q[0];
                    excp_flush_ack  = src_q[1];
                    irq_flush_ack   = src_q[2];
                    debug_flush_ack = src_q[3];
                    flush_cnt_d     = flush_cnt_q + 32'd1;
                    req_d           = 1'b0;
                    if (FLUSH_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            GAP: begin
                if (gap_q <= CNT_W'(1)) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            pc_q        <= '0;
            src_q       <= '0;
            gap_q       <= '0;
            flush_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pc_q        <= pc_d;
            src_q       <= src_d;
            gap_q       <= gap_d;
            flush_cnt_q <= flush_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign pipe_flush_req = req_q;
    assign pipe_flush_pc  = pc_q;
    assign pipe_flush_src = src_q;
    assign flush_busy     = busy_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_lnrv_exu_flush_sched.sv
// Directed bench for lnrv_exu_flush_sched: one gap-2 instance and one gap-0 instance.
module tb_lnrv_exu_flush_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        b_req, e_req, i_req, d_req, p_ack;
    logic [31:0] b_op1, b_op2, e_op1, e_op2, i_op1, i_op2, d_op1, d_op2;
    logic        b_ack, e_ack, i_ack, d_ack, p_req, busy;
    logic [31:0] p_pc, cnt;
    logic [3:0]  p_src, acks;
    assign acks = {d_ack, i_ack, e_ack, b_ack};

    logic        z_irq, z_pack, z0;
    logic [31:0] z_op1, z_op2, z32;
    logic        z_back, z_eack, z_iack, z_dack, z_preq, z_busy;
    logic [31:0] z_pc, z_cnt;
    logic [3:0]  z_src;

    int errors = 0;
    int checks = 0;

    lnrv_exu_flush_sched #(.FLUSH_GAP(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .brch_flush_req(b_req), .brch_flush_pc_op1(b_op1), .brch_flush_pc_op2(b_op2),
        .excp_flush_req(e_req), .excp_flush_pc_op1(e_op1), .excp_flush_pc_op2(e_op2),
        .irq_flush_req(i_req), .irq_flush_pc_op1(i_op1), .irq_flush_pc_op2(i_op2),
        .debug_flush_req(d_req), .debug_flush_pc_op1(d_op1), .debug_flush_pc_op2(d_op2),
        .brch_flush_ack(b_ack), .excp_flush_ack(e_ack), .irq_flush_ack(i_ack),
        .debug_flush_ack(d_ack), .pipe_flush_req(p_req), .pipe_flush_ack(p_ack),
        .pipe_flush_pc(p_pc), .pipe_flush_src(p_src), .flush_busy(busy), .flush_cnt(cnt)
    );

    lnrv_exu_flush_sched #(.FLUSH_GAP(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset),
        .brch_flush_req(z0), .brch_flush_pc_op1(z32), .brch_flush_pc_op2(z32),
        .excp_flush_req(z0), .excp_flush_pc_op1(z32), .excp_flush_pc_op2(z32),
        .irq_flush_req(z_irq), .irq_flush_pc_op1(z_op1), .irq_flush_pc_op2(z_op2),
        .debug_flush_req(z0), .debug_flush_pc_op1(z32), .debug_flush_pc_op2(z32),
        .brch_flush_ack(z_back), .excp_flush_ack(z_eack), .irq_flush_ack(z_iack),
        .debug_flush_ack(z_dack), .pipe_flush_req(z_preq), .pipe_flush_ack(z_pack),
        .pipe_flush_pc(z_pc), .pipe_flush_src(z_src), .flush_busy(z_busy), .flush_cnt(z_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({p_req, p_src, busy, acks} !== 10'b0 || p_pc !== 32'h0 || cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset: req=%b src=%b busy=%b acks=%b pc=%h cnt=%0d, required all 0",
                     p_req, p_src, busy, acks, p_pc, cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack;
        p_ack = 1'b1;
        #1;
        checks++;
        if (acks !== 4'b0) begin
            errors++; $display("FAIL stray_ack: acks=%b required 0000", acks);
        end
        tick();
        p_ack = 1'b0;
        checks++;
        if (cnt !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_cnt: cnt=%0d busy=%b required 0/0", cnt, busy);
        end
    endtask

    task automatic test_branch;
        int n;
        b_req = 1'b1; b_op1 = 32'h8000_0000; b_op2 = 32'h11;
        #1;
        checks++;
        if (p_req !== 1'b0) begin
            errors++; $display("FAIL brch_latency: req=%b required 0 before edge", p_req);
        end
        tick();
        checks++;
        if (p_req !== 1'b1 || p_pc !== 32'h8000_0010 || p_src !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL brch_issue: req=%b pc=%h src=%b busy=%b required 1/80000010/0001/1",
                     p_req, p_pc, p_src, busy);
        end
        p_ack = 1'b1;
        #1;
        checks++;
        if (acks !== 4'b0001) begin
            errors++; $display("FAIL brch_ack: acks=%b required 0001", acks);
        end
        tick();
        p_ack = 1'b0; b_req = 1'b0;
        checks++;
        if (acks !== 4'b0 || p_req !== 1'b0 || cnt !== 32'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL brch_after: acks=%b req=%b cnt=%0d busy=%b required 0000/0/1/1",
                     acks, p_req, cnt, busy);
        end
        wait_idle(n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL brch_gap: idle after %0d cycles, required 2", n);
        end
    endtask

    task automatic test_priority;
        logic [3:0]  exp_src [3];
        logic [31:0] exp_pc  [3];
        int low, n;
        exp_src[0] = 4'b0010; exp_pc[0] = 32'h0000_1234;
        exp_src[1] = 4'b0100; exp_pc[1] = 32'h0000_0010;
        exp_src[2] = 4'b1000; exp_pc[2] = 32'h0800_0000;
        e_req = 1'b1; e_op1 = 32'h0000_1000; e_op2 = 32'h0000_0235;
        i_req = 1'b1; i_op1 = 32'hFFFF_FFF0; i_op2 = 32'h0000_0020;
        d_req = 1'b1; d_op1 = 32'h0800_0001; d_op2 = 32'h0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (p_req !== 1'b1 || p_src !== exp_src[k] || p_pc !== exp_pc[k]) begin
                errors++;
                $display("FAIL prio_issue%0d: req=%b src=%b pc=%h required 1/%b/%h",
                         k, p_req, p_src, p_pc, exp_src[k], exp_pc[k]);
            end
            p_ack = 1'b1;
            #1;
            checks++;
            if (acks !== exp_src[k]) begin
                errors++; $display("FAIL prio_ack%0d: acks=%b required %b", k, acks, exp_src[k]);
            end
            tick();
            p_ack = 1'b0;
            if (k == 0) e_req = 1'b0;
            if (k == 1) i_req = 1'b0;
            if (k == 2) d_req = 1'b0;
            if (k < 2) begin
                low = 0;
                while (p_req !== 1'b1 && low < 20) begin
                    checks++;
                    if (acks !== 4'b0) begin
                        errors++; $display("FAIL prio_gap_ack%0d: acks=%b required 0000", k, acks);
                    end
                    low++;
                    tick();
                end
                checks++;
                if (low != 3) begin
                    errors++; $display("FAIL prio_low%0d: req low %0d cycles, required 3", k, low);
                end
            end
        end
        wait_idle(n);
        checks++;
        if (n >= 20 || cnt !== 32'd4) begin
            errors++; $display("FAIL prio_cnt: cnt=%0d idle_wait=%0d required cnt=4", cnt, n);
        end
    endtask

    task automatic test_no_preempt;
        int low, n;
        e_req = 1'b1; e_op1 = 32'h0000_2000; e_op2 = 32'h0000_0010;
        tick();
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin b_req = 1'b1; b_op1 = 32'h0000_3000; b_op2 = 32'h4; end
            if (c == 5) e_op1 = 32'h9999_0000;
            #1;
            checks++;
            if (p_req !== 1'b1 || p_pc !== 32'h0000_2010 || p_src !== 4'b0010 || acks !== 4'b0) begin
                errors++;
                $display("FAIL hold%0d: req=%b pc=%h src=%b acks=%b required 1/00002010/0010/0000",
                         c, p_req, p_pc, p_src, acks);
            end
            tick();
        end
        p_ack = 1'b1;
        #1;
        checks++;
        if (acks !== 4'b0010) begin
            errors++; $display("FAIL hold_ack: acks=%b required 0010", acks);
        end
        tick();
        p_ack = 1'b0; e_req = 1'b0;
        low = 0;
        while (p_req !== 1'b1 && low < 20) begin
            low++;
            tick();
        end
        checks++;
        if (low != 3 || p_src !== 4'b0001 || p_pc !== 32'h0000_3004) begin
            errors++;
            $display("FAIL waiter: low=%0d src=%b pc=%h required 3/0001/00003004", low, p_src, p_pc);
        end
        p_ack = 1'b1;
        #1;
        checks++;
        if (acks !== 4'b0001) begin
            errors++; $display("FAIL waiter_ack: acks=%b required 0001", acks);
        end
        tick();
        p_ack = 1'b0; b_req = 1'b0;
        wait_idle(n);
        checks++;
        if (cnt !== 32'd6) begin
            errors++; $display("FAIL hold_cnt: cnt=%0d required 6", cnt);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        b_req = 1'b1; b_op1 = 32'h0000_0100; b_op2 = 32'h0;
        tick();
        reset = 1'b1; p_ack = 1'b1;
        #1;
        checks++;
        if ({p_req, p_src, busy, acks} !== 10'b0 || p_pc !== 32'h0 || cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b src=%b busy=%b acks=%b pc=%h cnt=%0d required all 0",
                     p_req, p_src, busy, acks, p_pc, cnt);
        end
        p_ack = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (p_req !== 1'b0) begin
            errors++; $display("FAIL reset_rel: req=%b required 0 before first edge", p_req);
        end
        tick();
        checks++;
        if (p_req !== 1'b1 || p_src !== 4'b0001 || p_pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL reset_regrant: req=%b src=%b pc=%h required 1/0001/00000100", p_req, p_src, p_pc);
        end
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0; b_req = 1'b0;
        wait_idle(n);
        checks++;
        if (cnt !== 32'd1) begin
            errors++; $display("FAIL reset_cnt: cnt=%0d required 1", cnt);
        end
    endtask

    task automatic test_cnt_wrap;
        int n;
        e_req = 1'b1; e_op1 = 32'h40; e_op2 = 32'h0;
        tick();
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (cnt !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL cnt_preset: cnt=%h required ffffffff", cnt);
        end
        release dut.flush_cnt_q;
        p_ack = 1'b1;
        tick();
        p_ack = 1'b0; e_req = 1'b0;
        checks++;
        if (cnt !== 32'h0) begin
            errors++; $display("FAIL cnt_wrap: cnt=%h required 00000000", cnt);
        end
        wait_idle(n);
    endtask

    task automatic test_back_to_back;
        z_irq = 1'b1; z_op1 = 32'h0000_0500; z_op2 = 32'h0;
        tick();
        for (int k = 0; k < 3; k++) begin
            z_pack = 1'b1;
            #1;
            checks++;
            if (z_iack !== 1'b1 || z_src !== 4'b0100 || z_pc !== 32'h0000_0500) begin
                errors++;
                $display("FAIL b2b_ack%0d: iack=%b src=%b pc=%h required 1/0100/00000500", k, z_iack, z_src, z_pc);
            end
            tick();
            z_pack = 1'b0;
            checks++;
            if (z_preq !== 1'b0 || z_busy !== 1'b0) begin
                errors++; $display("FAIL b2b_low%0d: req=%b busy=%b required 0/0", k, z_preq, z_busy);
            end
            tick();
            checks++;
            if (z_preq !== 1'b1) begin
                errors++; $display("FAIL b2b_rise%0d: req=%b required 1", k, z_preq);
            end
        end
        z_irq = 1'b0;
        z_pack = 1'b1;
        tick();
        z_pack = 1'b0;
        checks++;
        if (z_cnt !== 32'd4 || z_preq !== 1'b0) begin
            errors++; $display("FAIL b2b_cnt: cnt=%0d req=%b required 4/0", z_cnt, z_preq);
        end
    endtask

    initial begin
        b_req = 0; e_req = 0; i_req = 0; d_req = 0; p_ack = 0;
        b_op1 = 0; b_op2 = 0; e_op1 = 0; e_op2 = 0; i_op1 = 0; i_op2 = 0; d_op1 = 0; d_op2 = 0;
        z_irq = 0; z_pack = 0; z0 = 0; z_op1 = 0; z_op2 = 0; z32 = 0;
        test_reset();
        test_stray_ack();
        test_branch();
        test_priority();
        test_no_preempt();
        test_reset_mid();
        test_cnt_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
